// File: rtl/ysyx_22050710_sram_rd_arbiter_pkg.sv
// Shared types for the instruction-SRAM read arbiter: sequencer state and response owner.
package ysyx_22050710_sram_rd_arbiter_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StResp = 1'b1
  } state_e;

  typedef enum logic {
    OwnerIfu = 1'b0,
    OwnerLsu = 1'b1
  } owner_e;

endpackage

// File: rtl/ysyx_22050710_rr_arb2.sv
// Two-way round-robin grant; a tie goes to the requester that did not win last.
module ysyx_22050710_rr_arb2
  import ysyx_22050710_sram_rd_arbiter_pkg::*;
(
  input  logic       i_en,
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  owner_e     i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      o_grant[0] = i_valid0 & (~i_valid1 | (i_last_grant == OwnerLsu));
      o_grant[1] = i_valid1 & (~i_valid0 | (i_last_grant == OwnerIfu));
    end
  end

endmodule

// File: rtl/ysyx_22050710_sram_rd_arbiter.sv
// Shares the single SRAM read port between IFU and LSU; one response outstanding at a time,
// 1-cycle read latency, back-to-back reads when the owner accepts its response immediately.
module ysyx_22050710_sram_rd_arbiter
  import ysyx_22050710_sram_rd_arbiter_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_WD = 32,
  parameter int unsigned SRAM_DATA_WD = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_ifu_req_valid,
  output logic                    o_ifu_req_ready,
  input  logic [SRAM_ADDR_WD-1:0] i_ifu_addr,
  output logic                    o_ifu_resp_valid,
  input  logic                    i_ifu_resp_ready,
  output logic [SRAM_DATA_WD-1:0] o_ifu_rdata,
  input  logic                    i_ifu_flush,
  input  logic                    i_lsu_req_valid,
  output logic                    o_lsu_req_ready,
  input  logic [SRAM_ADDR_WD-1:0] i_lsu_addr,
  output logic                    o_lsu_resp_valid,
  input  logic                    i_lsu_resp_ready,
  output logic [SRAM_DATA_WD-1:0] o_lsu_rdata,
  output logic                    o_sram_ren,
  output logic [SRAM_ADDR_WD-1:0] o_sram_addr,
  input  logic [SRAM_DATA_WD-1:0] i_sram_rdata
);

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  owner_e     last_grant_q, last_grant_d;
  logic       owner_resp_ready;
  logic       ifu_flushed;
  logic       slot_free;
  logic       arb_en;
  logic [1:0] grant;

  assign owner_resp_ready = (owner_q == OwnerIfu) ? i_ifu_resp_ready : i_lsu_resp_ready;
  assign ifu_flushed      = (state_q == StResp) & (owner_q == OwnerIfu) & i_ifu_flush;
  assign slot_free        = (state_q == StIdle) | ((state_q == StResp) & owner_resp_ready) |
                            ifu_flushed;
  // Outputs must read 0 while reset is held, including the combinational readies.
  assign arb_en           = slot_free & i_rst_n;

  ysyx_22050710_rr_arb2 u_rr_arb2 (
    .i_en         (arb_en),
    .i_valid0     (i_ifu_req_valid),
    .i_valid1     (i_lsu_req_valid),
    .i_last_grant (last_grant_q),
    .o_grant      (grant)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      owner_q      <= OwnerIfu;
      last_grant_q <= OwnerLsu;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    if (|grant) begin
      state_d      = StResp;
      owner_d      = grant[1] ? OwnerLsu : OwnerIfu;
      last_grant_d = owner_d;
    end else if (slot_free) begin
      state_d = StIdle;
    end
  end

  always_comb begin
    // Readies look only at the other requester's valid so neither depends on its own valid.
    o_ifu_req_ready = arb_en & (~i_lsu_req_valid | (last_grant_q == OwnerLsu));
    o_lsu_req_ready = arb_en & (~i_ifu_req_valid | (last_grant_q == OwnerIfu));

    o_sram_ren = |grant;
    unique case (grant)
      2'b01:   o_sram_addr = i_ifu_addr;
      2'b10:   o_sram_addr = i_lsu_addr;
      default: o_sram_addr = '0;
    endcase

    o_ifu_resp_valid = (state_q == StResp) & (owner_q == OwnerIfu) & ~i_ifu_flush;
    o_lsu_resp_valid = (state_q == StResp) & (owner_q == OwnerLsu);
    o_ifu_rdata      = o_ifu_resp_valid ? i_sram_rdata : '0;
    o_lsu_rdata      = o_lsu_resp_valid ? i_sram_rdata : '0;
  end

endmodule

// File: tb/tb_ysyx_22050710_sram_rd_arbiter.sv
// Directed bench for the SRAM read arbiter with a 1-cycle registered SRAM model.
module tb_ysyx_22050710_sram_rd_arbiter;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_ifu_req_valid;
  logic        o_ifu_req_ready;
  logic [31:0] i_ifu_addr;
  logic        o_ifu_resp_valid;
  logic        i_ifu_resp_ready;
  logic [63:0] o_ifu_rdata;
  logic        i_ifu_flush;
  logic        i_lsu_req_valid;
  logic        o_lsu_req_ready;
  logic [31:0] i_lsu_addr;
  logic        o_lsu_resp_valid;
  logic        i_lsu_resp_ready;
  logic [63:0] o_lsu_rdata;
  logic        o_sram_ren;
  logic [31:0] o_sram_addr;
  logic [63:0] i_sram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  ysyx_22050710_sram_rd_arbiter #(
    .SRAM_ADDR_WD (32),
    .SRAM_DATA_WD (64)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_ifu_req_valid  (i_ifu_req_valid),
    .o_ifu_req_ready  (o_ifu_req_ready),
    .i_ifu_addr       (i_ifu_addr),
    .o_ifu_resp_valid (o_ifu_resp_valid),
    .i_ifu_resp_ready (i_ifu_resp_ready),
    .o_ifu_rdata      (o_ifu_rdata),
    .i_ifu_flush      (i_ifu_flush),
    .i_lsu_req_valid  (i_lsu_req_valid),
    .o_lsu_req_ready  (o_lsu_req_ready),
    .i_lsu_addr       (i_lsu_addr),
    .o_lsu_resp_valid (o_lsu_resp_valid),
    .i_lsu_resp_ready (i_lsu_resp_ready),
    .o_lsu_rdata      (o_lsu_rdata),
    .o_sram_ren       (o_sram_ren),
    .o_sram_addr      (o_sram_addr),
    .i_sram_rdata     (i_sram_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [63:0] mem_val(input logic [31:0] a);
    if (a == 32'h8000_0000) return 64'h0000_0013_0000_0297;
    return {a ^ 32'hdead_beef, a};
  endfunction

  // SRAM model: registered read, output held while ren is low.
  logic [63:0] sram_q;
  always @(posedge i_clk) if (o_sram_ren) sram_q <= mem_val(o_sram_addr);
  assign i_sram_rdata = sram_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_ifu_req_valid  = 1'b0;
    i_ifu_addr       = '0;
    i_ifu_resp_ready = 1'b0;
    i_ifu_flush      = 1'b0;
    i_lsu_req_valid  = 1'b0;
    i_lsu_addr       = '0;
    i_lsu_resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    i_rst_n = 1'b1;
  endtask

  logic [31:0] prev_addr;
  logic        prev_lsu;

  initial begin
    sram_q  = '0;
    i_rst_n = 1'b0;
    idle_inputs();
    // Both requesting while reset is held: nothing may be granted.
    i_ifu_req_valid = 1'b1;
    i_lsu_req_valid = 1'b1;
    tick();
    #1;
    chk("rst_ifu_ready", 64'(o_ifu_req_ready), 64'd0);
    chk("rst_lsu_ready", 64'(o_lsu_req_ready), 64'd0);
    chk("rst_ren", 64'(o_sram_ren), 64'd0);
    chk("rst_ifu_rv", 64'(o_ifu_resp_valid), 64'd0);
    chk("rst_lsu_rv", 64'(o_lsu_resp_valid), 64'd0);
    chk("rst_addr", 64'(o_sram_addr), 64'd0);
    do_reset();

    // Single IFU read.
    i_ifu_req_valid  = 1'b1;
    i_ifu_addr       = 32'h8000_0000;
    i_ifu_resp_ready = 1'b1;
    #1;
    chk("t1_ready", 64'(o_ifu_req_ready), 64'd1);
    chk("t1_ren", 64'(o_sram_ren), 64'd1);
    chk("t1_addr", 64'(o_sram_addr), 64'h8000_0000);
    tick();
    i_ifu_req_valid = 1'b0;
    #1;
    chk("t1_rv", 64'(o_ifu_resp_valid), 64'd1);
    chk("t1_rdata", o_ifu_rdata, 64'h0000_0013_0000_0297);
    chk("t1_lsu_rv", 64'(o_lsu_resp_valid), 64'd0);
    chk("t1_ren_n1", 64'(o_sram_ren), 64'd0);
    tick();
    #1;
    chk("t1_rv_n2", 64'(o_ifu_resp_valid), 64'd0);
    do_reset();

    // Both valid every cycle: alternate IFU, LSU, ... starting with IFU.
    i_ifu_req_valid  = 1'b1;
    i_lsu_req_valid  = 1'b1;
    i_ifu_resp_ready = 1'b1;
    i_lsu_resp_ready = 1'b1;
    prev_addr        = '0;
    prev_lsu         = 1'b0;
    for (int k = 0; k < 6; k++) begin
      i_ifu_addr = 32'h0000_1000 + 32'(k * 4);
      i_lsu_addr = 32'h0000_2000 + 32'(k * 8);
      #1;
      chk("t2_ifu_ready", 64'(o_ifu_req_ready), 64'(k % 2 == 0));
      chk("t2_lsu_ready", 64'(o_lsu_req_ready), 64'(k % 2 == 1));
      chk("t2_ren", 64'(o_sram_ren), 64'd1);
      chk("t2_addr", 64'(o_sram_addr), 64'((k % 2 == 0) ? i_ifu_addr : i_lsu_addr));
      if (k > 0) begin
        chk("t2_ifu_rv", 64'(o_ifu_resp_valid), 64'(!prev_lsu));
        chk("t2_lsu_rv", 64'(o_lsu_resp_valid), 64'(prev_lsu));
        chk("t2_rdata", prev_lsu ? o_lsu_rdata : o_ifu_rdata, mem_val(prev_addr));
      end
      prev_addr = (k % 2 == 0) ? i_ifu_addr : i_lsu_addr;
      prev_lsu  = (k % 2 == 1);
      tick();
    end
    i_ifu_req_valid = 1'b0;
    i_lsu_req_valid = 1'b0;
    #1;
    chk("t2_last_lsu_rv", 64'(o_lsu_resp_valid), 64'd1);
    chk("t2_last_rdata", o_lsu_rdata, mem_val(32'h0000_2028));
    tick();
    do_reset();

    // LSU response held under backpressure while IFU waits.
    i_lsu_req_valid = 1'b1;
    i_lsu_addr      = 32'h0000_3000;
    #1;
    chk("t3_lsu_ready", 64'(o_lsu_req_ready), 64'd1);
    chk("t3_ren", 64'(o_sram_ren), 64'd1);
    tick();
    i_lsu_req_valid = 1'b0;
    i_ifu_req_valid = 1'b1;
    i_ifu_addr      = 32'h0000_4000;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_hold_rv", 64'(o_lsu_resp_valid), 64'd1);
      chk("t3_hold_rdata", o_lsu_rdata, mem_val(32'h0000_3000));
      chk("t3_hold_ifu_ready", 64'(o_ifu_req_ready), 64'd0);
      chk("t3_hold_ren", 64'(o_sram_ren), 64'd0);
      tick();
    end
    i_lsu_resp_ready = 1'b1;
    #1;
    chk("t3_accept_rv", 64'(o_lsu_resp_valid), 64'd1);
    chk("t3_accept_ifu_ready", 64'(o_ifu_req_ready), 64'd1);
    chk("t3_accept_ren", 64'(o_sram_ren), 64'd1);
    chk("t3_accept_addr", 64'(o_sram_addr), 64'h0000_4000);
    tick();

    // IFU response pending, then flushed while LSU requests.
    i_ifu_req_valid  = 1'b0;
    i_ifu_resp_ready = 1'b0;
    #1;
    chk("t4_pre_rv", 64'(o_ifu_resp_valid), 64'd1);
    chk("t4_pre_rdata", o_ifu_rdata, mem_val(32'h0000_4000));
    chk("t4_pre_lsu_rv", 64'(o_lsu_resp_valid), 64'd0);
    i_ifu_flush     = 1'b1;
    i_lsu_req_valid = 1'b1;
    i_lsu_addr      = 32'h0000_5000;
    #1;
    chk("t4_flush_rv", 64'(o_ifu_resp_valid), 64'd0);
    chk("t4_flush_rdata", o_ifu_rdata, 64'd0);
    chk("t4_flush_lsu_ready", 64'(o_lsu_req_ready), 64'd1);
    chk("t4_flush_ren", 64'(o_sram_ren), 64'd1);
    chk("t4_flush_addr", 64'(o_sram_addr), 64'h0000_5000);
    tick();
    i_ifu_flush     = 1'b0;
    i_lsu_req_valid = 1'b0;
    #1;
    chk("t4_lsu_rv", 64'(o_lsu_resp_valid), 64'd1);
    chk("t4_lsu_rdata", o_lsu_rdata, mem_val(32'h0000_5000));
    chk("t4_ifu_rv", 64'(o_ifu_resp_valid), 64'd0);
    chk("t4_ifu_rdata", o_ifu_rdata, 64'd0);
    tick();

    // Asynchronous reset while a response is outstanding.
    i_ifu_req_valid = 1'b1;
    i_ifu_addr      = 32'h0000_6000;
    #1;
    chk("t5_ifu_ready", 64'(o_ifu_req_ready), 64'd1);
    tick();
    i_lsu_req_valid = 1'b1;
    i_lsu_addr      = 32'h0000_7000;
    #1;
    chk("t5_pend_rv", 64'(o_ifu_resp_valid), 64'd1);
    chk("t5_pend_ren", 64'(o_sram_ren), 64'd0);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("t5_rst_ifu_rv", 64'(o_ifu_resp_valid), 64'd0);
    chk("t5_rst_lsu_rv", 64'(o_lsu_resp_valid), 64'd0);
    chk("t5_rst_ren", 64'(o_sram_ren), 64'd0);
    chk("t5_rst_ifu_ready", 64'(o_ifu_req_ready), 64'd0);
    tick();
    i_rst_n          = 1'b1;
    i_ifu_resp_ready = 1'b1;
    #1;
    chk("t5_tie_ifu_ready", 64'(o_ifu_req_ready), 64'd1);
    chk("t5_tie_lsu_ready", 64'(o_lsu_req_ready), 64'd0);
    chk("t5_tie_addr", 64'(o_sram_addr), 64'h0000_6000);
    tick();
    i_ifu_req_valid = 1'b0;
    i_lsu_req_valid = 1'b0;
    #1;
    chk("t5_post_rv", 64'(o_ifu_resp_valid), 64'd1);
    chk("t5_post_rdata", o_ifu_rdata, mem_val(32'h0000_6000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
